// File: rtl/div_16.sv
// Iterative unsigned restoring divider: one quotient bit per clock, start/busy/done handshake.
// States: IDLE = waiting for start | RUN = shift/subtract iterations | DONE = one-cycle result pulse.
module div_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_divisor;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_q_next;

  // Trial subtraction as a + ~b + 1; a non-borrowing result always has bit WIDTH clear.
  assign w_shift    = {r_rem, r_q[WIDTH-1]};
  assign w_sum      = {1'b0, w_shift} + {1'b0, ~{1'b0, r_divisor}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign w_carry    = w_sum[WIDTH+1] & ~w_sum[WIDTH];
  assign w_rem_next = w_carry ? w_sum[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign w_q_next   = {r_q[WIDTH-2:0], w_carry};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_q         <= '0;
      r_rem       <= '0;
      r_divisor   <= '0;
      r_cnt       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_divisor <= divisor;
            if (divisor == '0) begin
              r_state     <= S_DONE;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_state <= S_RUN;
              busy    <= 1'b1;
              r_q     <= dividend;
              r_rem   <= '0;
              r_cnt   <= CW'(WIDTH - 1);
            end
          end
        end
        S_RUN: begin
          r_q   <= w_q_next;
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= w_q_next;
            remainder   <= w_rem_next;
            div_by_zero <= 1'b0;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done    <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_16.md
Name: div_16

Overview:
- Multi-cycle 16-bit unsigned restoring divider; inverse of the 16-bit adder datapath.
- Computes quotient and remainder one bit per cycle.
- Each trial subtraction is done as a two's-complement add: a + ~b + 1.
- Sits beside the combinational arithmetic blocks as the ALU's iterative divide unit, with a start/busy/done handshake.

Parameters:
- WIDTH, 16, operand/result width. Only 16 is required to be supported; the iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  16  numerator; captured on accepted start
- divisor  input  16  denominator; captured on accepted start
- busy  output  1  high while iterating
- done  output  1  one-cycle pulse; results valid
- quotient  output  16  registered result
- remainder  output  16  registered result
- div_by_zero  output  1  registered flag for the last completed operation

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE.
  - busy, done, div_by_zero, quotient, remainder all 0.
  - Working registers cleared.
  - reset has priority over all other inputs, including mid-operation; an aborted operation never produces done.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 is accepted: dividend and divisor are captured.
  - If divisor!=0: next state RUN; working quotient shift reg = dividend; partial remainder (17 bits) = 0; iteration counter = 15.
  - If divisor==0: next state DONE directly.
  - start=0: stay in IDLE.
- RUN, one iteration per cycle:
  - r' = {r[15:0], q[15]}; q shifts left.
  - t = r' + ~{0,divisor} + 1 (17-bit).
  - Carry-out=1 (no borrow): r = t[16:0], new q[0]=1.
  - Otherwise: r = r', new q[0]=0.
  - After the counter=0 iteration, go to DONE.
- DONE, one cycle, then IDLE:
  - done=1, busy=0.
- Output registers:
  - quotient, remainder and div_by_zero update only on entry to DONE.
  - Between operations they hold their last values, including while busy.
- Divide-by-zero result: quotient=16'hFFFF, remainder=captured dividend, div_by_zero=1.
- Latency, measured from the cycle in which start is accepted (cycle 0):
  - Normal operation: busy=1 in cycles 1..16; done=1 in cycle 17 with results valid; IDLE in cycle 18.
  - Divide-by-zero: busy never asserts; done=1 in cycle 1.
- start while in RUN or DONE: ignored.
  - Changes to dividend/divisor after capture have no effect.
- Back-to-back: the earliest new accept is the cycle after DONE (cycle 18).
- busy and done are never both 1.
- div_by_zero is 0 for any completed nonzero-divisor operation.
- Arithmetic invariants for nonzero divisor:
  - quotient*divisor + remainder == dividend.
  - remainder < divisor.
  - No overflow case exists (unsigned).

Test Plan:
- dividend=100, divisor=7, start in cycle 0 -> busy cycles 1..16; done cycle 17; quotient=14, remainder=2, div_by_zero=0.
- 16'hFFFF / 1 -> quotient=16'hFFFF, remainder=0 at cycle 17; 16'hFFFF / 16'hFFFF -> quotient=1, remainder=0.
- 3 / 10 -> quotient=0, remainder=3; 0 / 5 -> quotient=0, remainder=0.
- 5 / 0 -> done in cycle 1, busy never high; quotient=16'hFFFF, remainder=5, div_by_zero=1; a following 9/3 clears div_by_zero (quotient=3, remainder=0).
- Start 100/7, then pulse start with 50/5 in cycle 5 and change inputs -> second request ignored; result 14/2 at cycle 17; outputs hold until the next accepted start.
- Start 1000/3, assert reset in cycle 8 -> from cycle 9: all outputs 0, state IDLE, no done pulse; a new 1000/3 started afterwards gives quotient=333, remainder=1 at 17 cycles after its accept.
